// File: rtl/seq_pkg.sv
// =============================================================================
//  Module   : seq_pkg
//  Purpose  : Shared types and RV32I opcode constants for the instruction sequencer
//  Revision : 1.0  initial release
// =============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    // Selects which target formula produces the next PC
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } pc_sel_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic pc_sel_t pc_sel_of(input logic [6:0] op);
        pc_sel_t sel;
        case (op)
            OP_BRANCH: sel = PC_BRANCH;
            OP_JAL:    sel = PC_JAL;
            OP_JALR:   sel = PC_JALR;
            default:   sel = PC_SEQ;
        endcase
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_next_unit.sv
// =============================================================================
//  Module   : pc_next_unit
//  Purpose  : Combinational next-PC selection and target alignment check
//  Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module pc_next_unit
    import seq_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm_32,
    input  logic [31:0] i_rs1_data,
    input  logic        i_branch_taken,
    input  pc_sel_t     i_pc_sel,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    logic [31:0] w_seq_pc;
    logic [31:0] w_rel_pc;
    logic [31:0] w_jalr_pc;

    assign w_seq_pc  = i_pc + 32'd4;
    assign w_rel_pc  = i_pc + i_imm_32;
    assign w_jalr_pc = (i_rs1_data + i_imm_32) & ~32'd1;

    always_comb begin
        o_next_pc = w_seq_pc;
        case (i_pc_sel)
            PC_BRANCH: o_next_pc = i_branch_taken ? w_rel_pc : w_seq_pc;
            PC_JAL:    o_next_pc = w_rel_pc;
            PC_JALR:   o_next_pc = w_jalr_pc;
            default:   o_next_pc = w_seq_pc;
        endcase
    end

    assign o_misaligned = |o_next_pc[1:0];

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// =============================================================================
//  Module   : instr_sequencer
//  Purpose  : Multi-cycle RV32I fetch/decode/execute/memory/writeback sequencer
//  Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module instr_sequencer
    import seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        en,
    input  logic [31:0] instr_in,
    input  logic        mem_ack,
    input  logic [6:0]  opcode,
    input  logic [31:0] imm_32,
    input  logic [31:0] rs1_data,
    input  logic        branch_taken,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        fetch_req,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        reg_write_en,
    output logic [2:0]  state,
    output logic        fault
);

    localparam int                  c_cnt_w    = $clog2(WAIT_LIMIT);
    localparam logic [c_cnt_w-1:0]  c_wait_max = c_cnt_w'(WAIT_LIMIT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [31:0]         r_pc;
    logic [31:0]         w_pc_next;
    logic [31:0]         r_instr;
    logic [31:0]         w_instr_next;
    logic [c_cnt_w-1:0]  r_wait_cnt;
    logic [c_cnt_w-1:0]  w_wait_next;
    logic                r_is_store;
    logic                w_is_store_next;
    logic                w_end_of_instr;
    logic [31:0]         w_target;
    logic                w_misaligned;

    pc_next_unit u_pc_next (
        .i_pc           (r_pc),
        .i_imm_32       (imm_32),
        .i_rs1_data     (rs1_data),
        .i_branch_taken (branch_taken),
        .i_pc_sel       (pc_sel_of(opcode)),
        .o_next_pc      (w_target),
        .o_misaligned   (w_misaligned)
    );

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_wait_cnt <= '0;
            r_is_store <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_wait_cnt <= w_wait_next;
            r_is_store <= w_is_store_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_instr_next    = r_instr;
        w_wait_next     = r_wait_cnt;
        w_is_store_next = r_is_store;
        w_end_of_instr  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_next = ST_FETCH;
                    w_wait_next  = '0;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    w_instr_next = instr_in;
                    w_state_next = ST_DECODE;
                end else if (r_wait_cnt == c_wait_max) begin
                    w_state_next = ST_FAULT;
                end else begin
                    w_wait_next = r_wait_cnt + 1'b1;
                end
            end
            ST_DECODE: begin
                w_state_next = is_legal_op(opcode) ? ST_EXECUTE : ST_FAULT;
            end
            ST_EXECUTE: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    w_state_next    = ST_MEMORY;
                    w_wait_next     = '0;
                    w_is_store_next = (opcode == OP_STORE);
                end else if (opcode == OP_BRANCH) begin
                    w_end_of_instr = 1'b1;
                end else begin
                    w_state_next = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (mem_ack) begin
                    if (r_is_store) begin
                        w_end_of_instr = 1'b1;
                    end else begin
                        w_state_next = ST_WRITEBACK;
                    end
                end else if (r_wait_cnt == c_wait_max) begin
                    w_state_next = ST_FAULT;
                end else begin
                    w_wait_next = r_wait_cnt + 1'b1;
                end
            end
            ST_WRITEBACK: begin
                w_end_of_instr = 1'b1;
            end
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
            default: begin
                w_state_next = ST_FAULT;
            end
        endcase

        // A misaligned target faults without committing the PC
        if (w_end_of_instr) begin
            if (w_misaligned) begin
                w_state_next = ST_FAULT;
            end else begin
                w_pc_next    = w_target;
                w_state_next = en ? ST_FETCH : ST_IDLE;
                w_wait_next  = '0;
            end
        end
    end

    assign fetch_req    = (r_state == ST_FETCH);
    assign dmem_read    = (r_state == ST_MEMORY) && !r_is_store;
    assign dmem_write   = (r_state == ST_MEMORY) &&  r_is_store;
    assign reg_write_en = (r_state == ST_WRITEBACK);
    assign fault        = (r_state == ST_FAULT);
    assign state        = r_state;
    assign pc           = r_pc;
    assign instruction  = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// =============================================================================
//  Module   : tb_instr_sequencer
//  Purpose  : Directed plus randomized check of instr_sequencer against a phase model
//  Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_instr_sequencer;

    localparam int          WL     = 16;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXECUTE = 3,
                   S_MEMORY = 4, S_WB = 5, S_FAULT = 6;

    localparam logic [6:0] M_R = 7'h33, M_I = 7'h13, M_LD = 7'h03, M_ST = 7'h23,
                           M_BR = 7'h63, M_JAL = 7'h6F, M_JALR = 7'h67,
                           M_LUI = 7'h37, M_AUIPC = 7'h17;

    logic        clk = 1'b0;
    logic        nRst, en, mem_ack, branch_taken;
    logic [31:0] instr_in, imm_32, rs1_data;
    logic [6:0]  opcode;
    logic [31:0] pc, instruction;
    logic        fetch_req, dmem_read, dmem_write, reg_write_en, fault;
    logic [2:0]  state;

    instr_sequencer #(.RESET_PC(RST_PC), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .nRst(nRst), .en(en), .instr_in(instr_in), .mem_ack(mem_ack),
        .opcode(opcode), .imm_32(imm_32), .rs1_data(rs1_data),
        .branch_taken(branch_taken), .pc(pc), .instruction(instruction),
        .fetch_req(fetch_req), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .reg_write_en(reg_write_en), .state(state), .fault(fault)
    );

    // Stand-in for control_unit: opcode decoded from the instruction register
    assign opcode = instruction[6:0];

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    int          obs_rd, obs_wr, obs_rwe;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_strobes(input int st, input bit is_store);
        case (st)
            S_FETCH:  return 32'b1000;
            S_MEMORY: return is_store ? 32'b0010 : 32'b0100;
            S_WB:     return 32'b0001;
            default:  return 32'b0000;
        endcase
    endfunction

    function automatic logic [31:0] strobes();
        return {28'd0, fetch_req, dmem_read, dmem_write, reg_write_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nRst = 1'b0; en = 1'b0; mem_ack = 1'b1; instr_in = $urandom;
        tick();
        check("rst_state", {29'd0, state}, S_IDLE);
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instruction, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_strobes", strobes(), 32'd0);
        nRst = 1'b1;
        m_pc = RST_PC;
        m_instr = 32'd0;
    endtask

    task automatic start_from_idle();
        en = 1'b1; mem_ack = 1'($urandom_range(0, 1));
        tick();
        check("start_state", {29'd0, state}, S_FETCH);
    endtask

    task automatic hold_fault();
        for (int k = 0; k < 3; k++) begin
            en = 1'($urandom_range(0, 1)); mem_ack = 1'($urandom_range(0, 1));
            tick();
            check("flt_state", {29'd0, state}, S_FAULT);
            check("flt_flag", {31'd0, fault}, 32'd1);
            check("flt_pc", pc, m_pc);
            check("flt_strobes", strobes(), 32'd0);
        end
    endtask

    // Build the expected per-cycle phase list from the instruction class and
    // memory delays, drive it, then check the committed PC or the fault.
    task automatic run_instr(input logic [31:0] word, input logic [31:0] imm,
                             input logic [31:0] rs1, input bit taken, input int fd,
                             input int md, input bit en_end, output bit faulted);
        int          q_st[$];
        bit          q_ack[$];
        logic [6:0]  op;
        bit          is_ld, is_st, legal, flt;
        logic [31:0] nxt, exp_instr;
        int          last;
        op = word[6:0];
        is_ld = (op == M_LD);
        is_st = (op == M_ST);
        legal = op inside {M_R, M_I, M_LD, M_ST, M_BR, M_JAL, M_JALR, M_LUI, M_AUIPC};
        flt = 1'b0;
        exp_instr = m_instr;
        nxt = m_pc;
        if (fd >= WL) begin
            for (int i = 0; i < WL; i++) begin q_st.push_back(S_FETCH); q_ack.push_back(1'b0); end
            flt = 1'b1;
        end else begin
            for (int i = 0; i <= fd; i++) begin q_st.push_back(S_FETCH); q_ack.push_back(i == fd); end
            exp_instr = word;
            q_st.push_back(S_DECODE); q_ack.push_back(1'b0);
            if (!legal) flt = 1'b1;
            else begin
                q_st.push_back(S_EXECUTE); q_ack.push_back(1'b0);
                if (is_ld || is_st) begin
                    if (md >= WL) begin
                        for (int i = 0; i < WL; i++) begin q_st.push_back(S_MEMORY); q_ack.push_back(1'b0); end
                        flt = 1'b1;
                    end else begin
                        for (int i = 0; i <= md; i++) begin q_st.push_back(S_MEMORY); q_ack.push_back(i == md); end
                        if (is_ld) begin q_st.push_back(S_WB); q_ack.push_back(1'b0); end
                    end
                end else if (op != M_BR) begin
                    q_st.push_back(S_WB); q_ack.push_back(1'b0);
                end
            end
        end
        if (!flt) begin
            case (op)
                M_JAL:   nxt = m_pc + imm;
                M_JALR:  nxt = (rs1 + imm) & 32'hFFFF_FFFE;
                M_BR:    nxt = taken ? m_pc + imm : m_pc + 32'd4;
                default: nxt = m_pc + 32'd4;
            endcase
            if (nxt[1:0] != 2'b00) flt = 1'b1;
        end
        obs_rd = 0; obs_wr = 0; obs_rwe = 0;
        last = q_st.size() - 1;
        for (int i = 0; i <= last; i++) begin
            check("state", {29'd0, state}, q_st[i]);
            check("strobes", strobes(), exp_strobes(q_st[i], is_st));
            obs_rd  += int'(dmem_read);
            obs_wr  += int'(dmem_write);
            obs_rwe += int'(reg_write_en);
            en = (i == last) ? en_end : 1'($urandom_range(0, 1));
            if (q_st[i] == S_FETCH || q_st[i] == S_MEMORY) mem_ack = q_ack[i];
            else mem_ack = 1'($urandom_range(0, 1));
            instr_in = (q_st[i] == S_FETCH && q_ack[i]) ? word : $urandom;
            imm_32 = imm;
            rs1_data = rs1;
            branch_taken = (q_st[i] == S_EXECUTE) ? taken : 1'($urandom_range(0, 1));
            tick();
        end
        m_instr = exp_instr;
        faulted = flt;
        if (flt) begin
            check("end_state", {29'd0, state}, S_FAULT);
            check("end_fault", {31'd0, fault}, 32'd1);
            check("end_pc", pc, m_pc);
            check("end_instr", instruction, m_instr);
        end else begin
            m_pc = nxt;
            check("end_state", {29'd0, state}, en_end ? S_FETCH : S_IDLE);
            check("end_fault", {31'd0, fault}, 32'd0);
            check("end_pc", pc, m_pc);
            check("end_instr", instruction, m_instr);
            if (!en_end) begin
                check("idle_strobes", strobes(), 32'd0);
                start_from_idle();
            end
        end
    endtask

    task automatic reset_mid_memory();
        logic [31:0] r;
        r = $urandom;
        en = 1'b1; mem_ack = 1'b1; instr_in = {r[31:7], M_LD};
        tick();
        mem_ack = 1'b0;
        tick();
        tick();
        check("mid_mem_state", {29'd0, state}, S_MEMORY);
        check("mid_mem_read", {31'd0, dmem_read}, 32'd1);
        nRst = 1'b0;
        tick();
        check("mid_rst_state", {29'd0, state}, S_IDLE);
        check("mid_rst_read", {31'd0, dmem_read}, 32'd0);
        check("mid_rst_pc", pc, RST_PC);
        nRst = 1'b1;
        m_pc = RST_PC;
        m_instr = 32'd0;
    endtask

    function automatic logic [31:0] mk_word(input logic [6:0] op);
        logic [31:0] r;
        r = $urandom;
        return {r[31:7], op};
    endfunction

    initial begin
        bit          f;
        logic [6:0]  ops [9] = '{M_R, M_I, M_LD, M_ST, M_BR, M_JAL, M_JALR, M_LUI, M_AUIPC};
        logic [6:0]  op;
        logic [31:0] imm, rs1;
        int          fd, md;

        nRst = 1'b0; en = 1'b0; mem_ack = 1'b0; instr_in = 32'd0;
        imm_32 = 32'd0; rs1_data = 32'd0; branch_taken = 1'b0;
        m_pc = RST_PC; m_instr = 32'd0;

        do_reset();
        start_from_idle();
        run_instr(32'h002081B3, 32'd0, 32'd0, 1'b0, 0, 0, 1'b1, f);
        check("t1_pc", pc, 32'h4);
        check("t1_rwe", obs_rwe, 1);
        run_instr(32'h0000A103, 32'd0, 32'd0, 1'b0, 0, 3, 1'b1, f);
        check("t2_rd_cycles", obs_rd, 4);
        check("t2_rwe", obs_rwe, 1);
        run_instr(mk_word(M_BR), 32'h30, 32'd0, 1'b1, 0, 0, 1'b1, f);
        check("t3_taken_pc", pc, 32'h38);
        check("t3_rwe", obs_rwe, 0);
        run_instr(mk_word(M_JALR), 32'd0, 32'h8, 1'b0, 0, 0, 1'b1, f);
        run_instr(mk_word(M_BR), 32'h30, 32'd0, 1'b0, 0, 0, 1'b0, f);
        check("t3_not_taken_pc", pc, 32'hC);
        check("t3_rwe_nt", obs_rwe, 0);
        run_instr(mk_word(M_ST), 32'd0, 32'd0, 1'b0, 0, 2, 1'b1, f);
        check("store_wr_cycles", obs_wr, 3);
        reset_mid_memory();
        start_from_idle();
        run_instr(mk_word(M_JALR), 32'h4, 32'h101, 1'b0, 0, 0, 1'b1, f);
        check("t4_jalr_pc", pc, 32'h104);
        run_instr(mk_word(M_JAL), 32'h2, 32'd0, 1'b0, 0, 0, 1'b1, f);
        check("t4_jal_pc_held", pc, 32'h104);
        hold_fault();
        do_reset();
        start_from_idle();
        run_instr(mk_word(M_R), 32'd0, 32'd0, 1'b0, WL - 1, 0, 1'b1, f);
        run_instr(mk_word(M_LD), 32'd0, 32'd0, 1'b0, 0, WL - 1, 1'b1, f);
        run_instr(mk_word(M_R), 32'd0, 32'd0, 1'b0, WL, 0, 1'b1, f);
        hold_fault();
        do_reset();
        start_from_idle();
        run_instr(mk_word(M_ST), 32'd0, 32'd0, 1'b0, 0, WL, 1'b1, f);
        hold_fault();
        do_reset();
        start_from_idle();
        run_instr(mk_word(7'h7F), 32'd0, 32'd0, 1'b0, 0, 0, 1'b1, f);
        hold_fault();
        do_reset();
        start_from_idle();

        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            imm = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) imm = $urandom;
            rs1 = $urandom;
            if ($urandom_range(0, 3) != 0) rs1 = rs1 & 32'hFFFF_FFFC;
            fd = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(0, WL);
            md = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(0, WL);
            run_instr(mk_word(op), imm, rs1, 1'($urandom_range(0, 1)), fd, md,
                      1'($urandom_range(0, 1)), f);
            if (f) begin
                hold_fault();
                do_reset();
                start_from_idle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
